// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared definitions for the alarm ring controller: state encoding, BCD limits
// and BCD/binary helpers used by the snooze adder.
package alarm_ring_ctrl_pkg;

  localparam int BCD_W = 8;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MIN_MAX  = 8'h59;
  localparam bcd_t BCD_HOUR_MAX = 8'h23;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  function automatic logic [6:0] bcd_to_bin(input bcd_t v);
    return ({3'b000, v[7:4]} * 7'd10) + {3'b000, v[3:0]};
  endfunction

  // Valid only for 0..99, which covers every minute/hour value produced here.
  function automatic bcd_t bin_to_bcd(input logic [6:0] b);
    logic [7:0] w;
    w = {1'b0, b};
    return ((w / 8'd10) << 4) | (w % 8'd10);
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_bcd_time_add.sv
// Combinational BCD hh:mm plus a fixed minute count (1..59), wrapping minutes
// at 59 with carry into the hour and hours at 23.
module bcd_time_add
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int ADD_MIN = 5
) (
  input  logic [BCD_W-1:0] hour,
  input  logic [BCD_W-1:0] min,
  output logic [BCD_W-1:0] sum_hour,
  output logic [BCD_W-1:0] sum_min
);

  logic [6:0] min_sum;
  logic [6:0] min_wrap;
  logic       carry;

  assign min_sum  = bcd_to_bin(min) + 7'(ADD_MIN);
  assign carry    = min_sum > bcd_to_bin(BCD_MIN_MAX);
  assign min_wrap = carry ? (min_sum - 7'd60) : min_sum;
  assign sum_min  = bin_to_bcd(min_wrap);

  always_comb begin
    sum_hour = hour;
    if (carry) begin
      if (hour == BCD_HOUR_MAX) sum_hour = 8'h00;
      else                      sum_hour = bin_to_bcd(bcd_to_bin(hour) + 7'd1);
    end
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencing: match against target time, ring with timeout, stop and
// snooze re-targeting. Snooze support is built only with ALARM_SNOOZE_EN.
//
// state   | meaning
// IDLE    | alarm disabled, target follows alert setting
// ARMED   | waiting for target match, target follows alert setting
// RINGING | ring output active, counting seconds toward auto-stop
// SNOOZE  | target held at snooze time, waiting for match
module alarm_ring_ctrl
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic             Clk,
  input  logic             RST,
  input  logic             Sec_Tick,
  input  logic [BCD_W-1:0] CurHour,
  input  logic [BCD_W-1:0] CurMin,
  input  logic [BCD_W-1:0] CurSec,
  input  logic [BCD_W-1:0] AlertHour,
  input  logic [BCD_W-1:0] AlertMin,
  input  logic             Alarm_EN,
  input  logic             Snooze,
  input  logic             Stop,
  output logic             Ring,
  output logic             Snoozing,
  output logic [3:0]       SnzCnt,
  output logic [BCD_W-1:0] TgtHour,
  output logic [BCD_W-1:0] TgtMin,
  output logic [1:0]       State
);

  state_t     state, state_nxt;
  logic [7:0] ring_cnt, ring_cnt_nxt;
  logic [3:0] snz_cnt, snz_cnt_nxt;
  bcd_t       tgt_hour, tgt_hour_nxt;
  bcd_t       tgt_min, tgt_min_nxt;

  logic       match;
  logic [8:0] tick_cnt;
  logic       timeout;
  logic       snooze_ok;

  assign match    = Sec_Tick && (CurSec == 8'h00) &&
                    (CurHour == tgt_hour) && (CurMin == tgt_min);
  assign tick_cnt = {1'b0, ring_cnt} + 9'd1;
  assign timeout  = Sec_Tick && (tick_cnt == 9'(RING_SEC));

`ifdef ALARM_SNOOZE_EN
  bcd_t snz_hour, snz_min;

  bcd_time_add #(.ADD_MIN(SNOOZE_MIN)) u_snz_add (
    .hour     (CurHour),
    .min      (CurMin),
    .sum_hour (snz_hour),
    .sum_min  (snz_min)
  );

  assign snooze_ok = Snooze && (snz_cnt < 4'(MAX_SNOOZE));
`else
  logic unused_snooze_cfg;
  assign unused_snooze_cfg = ^{Snooze, 4'(MAX_SNOOZE), 6'(SNOOZE_MIN)};
  assign snooze_ok = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    ring_cnt_nxt = ring_cnt;
    snz_cnt_nxt  = snz_cnt;
    tgt_hour_nxt = tgt_hour;
    tgt_min_nxt  = tgt_min;

    case (state)
      IDLE: begin
        tgt_hour_nxt = AlertHour;
        tgt_min_nxt  = AlertMin;
        state_nxt    = ARMED;
      end
      ARMED: begin
        tgt_hour_nxt = AlertHour;
        tgt_min_nxt  = AlertMin;
        if (match) begin
          state_nxt    = RINGING;
          ring_cnt_nxt = '0;
        end
      end
      RINGING: begin
        if (Sec_Tick) ring_cnt_nxt = tick_cnt[7:0];
        if (Stop) begin
          state_nxt   = ARMED;
          snz_cnt_nxt = '0;
        end else if (snooze_ok) begin
          state_nxt   = SNOOZE;
          snz_cnt_nxt = snz_cnt + 4'd1;
`ifdef ALARM_SNOOZE_EN
          tgt_hour_nxt = snz_hour;
          tgt_min_nxt  = snz_min;
`endif
        end else if (timeout) begin
          state_nxt   = ARMED;
          snz_cnt_nxt = '0;
        end
      end
      SNOOZE: begin
        if (Stop) begin
          state_nxt   = ARMED;
          snz_cnt_nxt = '0;
        end else if (match) begin
          state_nxt    = RINGING;
          ring_cnt_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifndef ALARM_SNOOZE_EN
    tgt_hour_nxt = AlertHour;
    tgt_min_nxt  = AlertMin;
`endif

    // Disable overrides every other event, including a coincident match.
    if (!Alarm_EN) begin
      state_nxt   = IDLE;
      snz_cnt_nxt = '0;
    end
  end

  always_ff @(posedge Clk or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      ring_cnt <= '0;
      snz_cnt  <= '0;
      tgt_hour <= 8'h00;
      tgt_min  <= 8'h00;
    end else begin
      state    <= state_nxt;
      ring_cnt <= ring_cnt_nxt;
      snz_cnt  <= snz_cnt_nxt;
      tgt_hour <= tgt_hour_nxt;
      tgt_min  <= tgt_min_nxt;
    end
  end

  assign Ring     = (state == RINGING);
  assign Snoozing = (state == SNOOZE);
  assign State    = state;
  assign SnzCnt   = snz_cnt;
  assign TgtHour  = tgt_hour;
  assign TgtMin   = tgt_min;

endmodule
